// File: rtl/coherence_bus_ctrl.sv
// coherence_bus_ctrl
// Controller end of the dual-core cache/coherence interface. Arbitrates the
// I- and D-cache requests of two cores onto a single RAM port and runs a
// snooping MSI protocol toward the D-cache of the non-requesting core.
//
// Ports
//   CLK, nRST          clock (rising edge), synchronous active-low reset
//   iREN/iaddr         per-core I-cache read request and address
//   iwait/iload        per-core I-request stall and read data
//   dREN/dWEN          per-core D-cache read / write request
//   daddr/dstore       per-core D address and write (or snoop response) data
//   dwait/dload        per-core D-request stall and read data
//   cctrans/ccwrite    per-core coherence transition / write-intent or Modified
//   ccwait/ccinv       stall / invalidate toward the snooped cache
//   ccsnoopaddr        snoop address toward the snooped cache
//   ramREN/ramWEN      RAM read / write strobes
//   ramaddr/ramstore   RAM address / write data
//   ramload/ramstate   RAM read data and status (FREE/BUSY/ACCESS/ERROR)
//   dbg_state          current controller state, for observation only
//
// Handshake: a request is held by the cache until its wait line drops for
// exactly one cycle, which happens combinationally in the cycle RAM reports
// ACCESS (or in the single SNOOP cycle for an upgrade). The controller
// returns to IDLE on the following edge, and a new grant is made no earlier
// than the cycle after that.
module coherence_bus_ctrl #(
    parameter int CPUS = 2
) (
    input  logic                 CLK,
    input  logic                 nRST,
    input  logic [CPUS-1:0]      iREN,
    input  logic [CPUS-1:0][31:0] iaddr,
    output logic [CPUS-1:0]      iwait,
    output logic [CPUS-1:0][31:0] iload,
    input  logic [CPUS-1:0]      dREN,
    input  logic [CPUS-1:0]      dWEN,
    input  logic [CPUS-1:0][31:0] daddr,
    input  logic [CPUS-1:0][31:0] dstore,
    output logic [CPUS-1:0]      dwait,
    output logic [CPUS-1:0][31:0] dload,
    input  logic [CPUS-1:0]      cctrans,
    input  logic [CPUS-1:0]      ccwrite,
    output logic [CPUS-1:0]      ccwait,
    output logic [CPUS-1:0]      ccinv,
    output logic [CPUS-1:0][31:0] ccsnoopaddr,
    output logic                 ramREN,
    output logic                 ramWEN,
    output logic [31:0]          ramaddr,
    output logic [31:0]          ramstore,
    input  logic [31:0]          ramload,
    input  logic [1:0]           ramstate,
    output logic [2:0]           dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SNOOP  = 3'd1,
        S_C2C    = 3'd2,
        S_RAMRD  = 3'd3,
        S_RAMWR  = 3'd4,
        S_IFETCH = 3'd5
    } state_t;

    localparam logic [1:0] RAM_ACCESS = 2'b10;

    state_t      state_q, state_d;
    logic        rr_q, rr_d;       // core preferred for the next D-grant
    logic        req_q, req_d;     // core being served
    logic        upg_q, upg_d;     // current snoop is an S->M upgrade
    logic [31:0] addr_q, addr_d;   // latched D address for snoop/fill
    logic [31:0] data_q, data_d;   // latched Modified block from the snooped cache

    logic            access;
    logic            oth;
    logic            gnt;
    logic [CPUS-1:0] dreq;

    assign dbg_state = state_q;
    assign access    = (ramstate == RAM_ACCESS);
    assign oth       = ~req_q;

    // An upgrade (cctrans & ccwrite without dREN) competes as a D-request.
    assign dreq = dREN | dWEN | (cctrans & ccwrite);
    assign gnt  = dreq[rr_q] ? rr_q : ~rr_q;

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q <= S_IDLE;
            rr_q    <= 1'b0;
            req_q   <= 1'b0;
            upg_q   <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            req_q   <= req_d;
            upg_q   <= upg_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        rr_d        = rr_q;
        req_d       = req_q;
        upg_d       = upg_q;
        addr_d      = addr_q;
        data_d      = data_q;
        iwait       = '1;
        dwait       = '1;
        iload       = '0;
        dload       = '0;
        ccwait      = '0;
        ccinv       = '0;
        ccsnoopaddr = '0;
        ramREN      = 1'b0;
        ramWEN      = 1'b0;
        ramaddr     = '0;
        ramstore    = '0;

        case (state_q)
            S_IDLE: begin
                if (|dreq) begin
                    req_d  = gnt;
                    addr_d = daddr[gnt];
                    upg_d  = 1'b0;
                    if (dWEN[gnt]) begin
                        // Writebacks go straight to RAM without snooping.
                        state_d = S_RAMWR;
                    end else if (dREN[gnt]) begin
                        state_d = cctrans[gnt] ? S_SNOOP : S_RAMRD;
                    end else begin
                        upg_d   = 1'b1;
                        state_d = S_SNOOP;
                    end
                end else if (|iREN) begin
                    req_d   = ~iREN[0];
                    state_d = S_IFETCH;
                end
            end

            S_SNOOP: begin
                // The snooped cache answers combinationally in this cycle.
                ccwait[oth]      = 1'b1;
                ccsnoopaddr[oth] = addr_q;
                ccinv[oth]       = ccwrite[req_q];
                if (upg_q) begin
                    dwait[req_q] = 1'b0;
                    rr_d         = oth;
                    state_d      = S_IDLE;
                end else if (ccwrite[oth]) begin
                    data_d  = dstore[oth];
                    state_d = S_C2C;
                end else begin
                    state_d = S_RAMRD;
                end
            end

            S_C2C: begin
                // Forward the Modified block to the requester and write it
                // back to RAM in the same transfer.
                ccwait[oth]  = 1'b1;
                ramWEN       = 1'b1;
                ramaddr      = addr_q;
                ramstore     = data_q;
                dload[req_q] = data_q;
                if (access) begin
                    dwait[req_q] = 1'b0;
                    rr_d         = oth;
                    state_d      = S_IDLE;
                end
            end

            S_RAMRD: begin
                ramREN  = 1'b1;
                ramaddr = addr_q;
                if (access) begin
                    dload[req_q] = ramload;
                    dwait[req_q] = 1'b0;
                    rr_d         = oth;
                    state_d      = S_IDLE;
                end
            end

            S_RAMWR: begin
                ramWEN   = 1'b1;
                ramaddr  = daddr[req_q];
                ramstore = dstore[req_q];
                if (access) begin
                    dwait[req_q] = 1'b0;
                    rr_d         = oth;
                    state_d      = S_IDLE;
                end
            end

            S_IFETCH: begin
                ramREN  = 1'b1;
                ramaddr = iaddr[req_q];
                if (access) begin
                    iload[req_q] = ramload;
                    iwait[req_q] = 1'b0;
                    state_d      = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_coherence_bus_ctrl.sv
// Testbench for coherence_bus_ctrl: a cycle-by-cycle table of inputs and
// hand-computed expected outputs, followed by hand-written sequences for
// reset during a transaction and a request dropped mid-transaction.
module tb_coherence_bus_ctrl;

    localparam logic [1:0] FR = 2'b00;
    localparam logic [1:0] BS = 2'b01;
    localparam logic [1:0] AC = 2'b10;
    localparam logic [1:0] ER = 2'b11;

    logic             CLK;
    logic             nRST;
    logic [1:0]       iREN;
    logic [1:0][31:0] iaddr;
    logic [1:0]       iwait;
    logic [1:0][31:0] iload;
    logic [1:0]       dREN;
    logic [1:0]       dWEN;
    logic [1:0][31:0] daddr;
    logic [1:0][31:0] dstore;
    logic [1:0]       dwait;
    logic [1:0][31:0] dload;
    logic [1:0]       cctrans;
    logic [1:0]       ccwrite;
    logic [1:0]       ccwait;
    logic [1:0]       ccinv;
    logic [1:0][31:0] ccsnoopaddr;
    logic             ramREN;
    logic             ramWEN;
    logic [31:0]      ramaddr;
    logic [31:0]      ramstore;
    logic [31:0]      ramload;
    logic [1:0]       ramstate;
    logic [2:0]       dbg_state;

    int n_checks;
    int n_fail;

    coherence_bus_ctrl #(.CPUS(2)) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload),
        .cctrans(cctrans), .ccwrite(ccwrite), .ccwait(ccwait), .ccinv(ccinv),
        .ccsnoopaddr(ccsnoopaddr),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate),
        .dbg_state(dbg_state)
    );

    // Clock / reset
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    typedef struct {
        logic        nrst;
        logic [1:0]  iren, dren, dwen, cct, ccw, rs;
        logic [31:0] ld, da0, da1, ds0, ds1;
    } in_t;

    typedef struct {
        logic [1:0]  iw, dw, ccw, cci;
        logic [31:0] snp0, snp1;
        logic        ren, wen;
        logic [31:0] ra, rst, dl0, dl1, il0, il1;
    } exp_t;

    typedef struct {
        in_t  i;
        exp_t e;
    } vec_t;

    vec_t tv[$];

    function automatic in_t mi(logic nrst, logic [1:0] iren, logic [1:0] dren,
                               logic [1:0] dwen, logic [1:0] cct, logic [1:0] ccw,
                               logic [1:0] rs, logic [31:0] ld, logic [31:0] da0,
                               logic [31:0] da1, logic [31:0] ds0, logic [31:0] ds1);
        in_t v;
        v.nrst = nrst; v.iren = iren; v.dren = dren; v.dwen = dwen;
        v.cct = cct; v.ccw = ccw; v.rs = rs; v.ld = ld;
        v.da0 = da0; v.da1 = da1; v.ds0 = ds0; v.ds1 = ds1;
        return v;
    endfunction

    function automatic exp_t me(logic [1:0] iw, logic [1:0] dw, logic [1:0] ccw,
                                logic [1:0] cci, logic [31:0] snp0, logic [31:0] snp1,
                                logic ren, logic wen, logic [31:0] ra, logic [31:0] rst,
                                logic [31:0] dl0, logic [31:0] dl1, logic [31:0] il0,
                                logic [31:0] il1);
        exp_t e;
        e.iw = iw; e.dw = dw; e.ccw = ccw; e.cci = cci;
        e.snp0 = snp0; e.snp1 = snp1; e.ren = ren; e.wen = wen;
        e.ra = ra; e.rst = rst; e.dl0 = dl0; e.dl1 = dl1; e.il0 = il0; e.il1 = il1;
        return e;
    endfunction

    // Driver tasks
    task automatic drive(input in_t v);
        nRST     = v.nrst;
        iREN     = v.iren;
        dREN     = v.dren;
        dWEN     = v.dwen;
        cctrans  = v.cct;
        ccwrite  = v.ccw;
        ramstate = v.rs;
        ramload  = v.ld;
        daddr    = {v.da1, v.da0};
        dstore   = {v.ds1, v.ds0};
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_all(input int r, input exp_t e);
        check($sformatf("row%0d iwait", r), 64'(iwait), 64'(e.iw));
        check($sformatf("row%0d dwait", r), 64'(dwait), 64'(e.dw));
        check($sformatf("row%0d ccwait", r), 64'(ccwait), 64'(e.ccw));
        check($sformatf("row%0d ccinv", r), 64'(ccinv), 64'(e.cci));
        check($sformatf("row%0d ccsnoopaddr", r), ccsnoopaddr, {e.snp1, e.snp0});
        check($sformatf("row%0d ramREN", r), 64'(ramREN), 64'(e.ren));
        check($sformatf("row%0d ramWEN", r), 64'(ramWEN), 64'(e.wen));
        check($sformatf("row%0d ramaddr", r), 64'(ramaddr), 64'(e.ra));
        check($sformatf("row%0d ramstore", r), 64'(ramstore), 64'(e.rst));
        check($sformatf("row%0d dload", r), dload, {e.dl1, e.dl0});
        check($sformatf("row%0d iload", r), iload, {e.il1, e.il0});
    endtask

    initial begin
        exp_t id;
        in_t  z;
        n_checks = 0;
        n_fail   = 0;
        id = me(2'b11, 2'b11, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        z  = mi(1, 0, 0, 0, 0, 0, FR, 0, 0, 0, 0, 0);

        // Reset held with requests pending, then an I-fetch with two BUSY cycles.
        tv.push_back('{mi(0, 2'b01, 2'b01, 0, 0, 0, FR, 0, 0, 0, 0, 0), id});
        tv.push_back('{mi(0, 2'b01, 2'b01, 0, 0, 0, FR, 0, 0, 0, 0, 0), id});
        tv.push_back('{mi(1, 2'b01, 0, 0, 0, 0, FR, 0, 0, 0, 0, 0), id});
        tv.push_back('{mi(1, 2'b01, 0, 0, 0, 0, BS, 0, 0, 0, 0, 0), me(2'b11, 2'b11, 0, 0, 0, 0, 1, 0, 32'h40, 0, 0, 0, 0, 0)});
        tv.push_back('{mi(1, 2'b01, 0, 0, 0, 0, BS, 0, 0, 0, 0, 0), me(2'b11, 2'b11, 0, 0, 0, 0, 1, 0, 32'h40, 0, 0, 0, 0, 0)});
        tv.push_back('{mi(1, 2'b01, 0, 0, 0, 0, AC, 32'hDEADBEEF, 0, 0, 0, 0), me(2'b10, 2'b11, 0, 0, 0, 0, 1, 0, 32'h40, 0, 0, 0, 32'hDEADBEEF, 0)});
        tv.push_back('{z, id});
        // Cache-to-cache: core0 reads 0x100, core1 holds it Modified.
        tv.push_back('{mi(1, 0, 2'b01, 0, 2'b01, 0, FR, 0, 32'h100, 0, 0, 0), id});
        tv.push_back('{mi(1, 0, 2'b01, 0, 2'b01, 2'b10, FR, 0, 32'h100, 0, 0, 32'h12345678), me(2'b11, 2'b11, 2'b10, 0, 0, 32'h100, 0, 0, 0, 0, 0, 0, 0, 0)});
        tv.push_back('{mi(1, 0, 2'b01, 0, 2'b01, 0, BS, 0, 32'h100, 0, 0, 0), me(2'b11, 2'b11, 2'b10, 0, 0, 0, 0, 1, 32'h100, 32'h12345678, 32'h12345678, 0, 0, 0)});
        tv.push_back('{mi(1, 0, 2'b01, 0, 2'b01, 0, AC, 0, 32'h100, 0, 0, 0), me(2'b11, 2'b10, 2'b10, 0, 0, 0, 0, 1, 32'h100, 32'h12345678, 32'h12345678, 0, 0, 0)});
        tv.push_back('{z, id});
        // Upgrade by core1 at 0x200.
        tv.push_back('{mi(1, 0, 0, 0, 2'b10, 2'b10, FR, 0, 0, 32'h200, 0, 0), id});
        tv.push_back('{mi(1, 0, 0, 0, 2'b10, 2'b10, FR, 0, 0, 32'h200, 0, 0), me(2'b11, 2'b01, 2'b01, 2'b01, 32'h200, 0, 0, 0, 0, 0, 0, 0, 0, 0)});
        tv.push_back('{z, id});
        // Both cores write repeatedly with iREN held: 0, 1, 0, then I-fetches.
        tv.push_back('{mi(1, 2'b11, 0, 2'b11, 0, 0, FR, 0, 32'hA0, 32'hB0, 32'h1111, 32'h2222), id});
        tv.push_back('{mi(1, 2'b11, 0, 2'b11, 0, 0, AC, 0, 32'hA0, 32'hB0, 32'h1111, 32'h2222), me(2'b11, 2'b10, 0, 0, 0, 0, 0, 1, 32'hA0, 32'h1111, 0, 0, 0, 0)});
        tv.push_back('{mi(1, 2'b11, 0, 2'b11, 0, 0, FR, 0, 32'hA0, 32'hB0, 32'h1111, 32'h2222), id});
        tv.push_back('{mi(1, 2'b11, 0, 2'b11, 0, 0, AC, 0, 32'hA0, 32'hB0, 32'h1111, 32'h2222), me(2'b11, 2'b01, 0, 0, 0, 0, 0, 1, 32'hB0, 32'h2222, 0, 0, 0, 0)});
        tv.push_back('{mi(1, 2'b11, 0, 2'b11, 0, 0, FR, 0, 32'hA0, 32'hB0, 32'h1111, 32'h2222), id});
        tv.push_back('{mi(1, 2'b11, 0, 2'b11, 0, 0, AC, 0, 32'hA0, 32'hB0, 32'h1111, 32'h2222), me(2'b11, 2'b10, 0, 0, 0, 0, 0, 1, 32'hA0, 32'h1111, 0, 0, 0, 0)});
        tv.push_back('{mi(1, 2'b11, 0, 0, 0, 0, FR, 0, 0, 0, 0, 0), id});
        tv.push_back('{mi(1, 2'b11, 0, 0, 0, 0, AC, 32'h55, 0, 0, 0, 0), me(2'b10, 2'b11, 0, 0, 0, 0, 1, 0, 32'h40, 0, 0, 0, 32'h55, 0)});
        tv.push_back('{mi(1, 2'b10, 0, 0, 0, 0, FR, 0, 0, 0, 0, 0), id});
        tv.push_back('{mi(1, 2'b10, 0, 0, 0, 0, AC, 32'h66, 0, 0, 0, 0), me(2'b01, 2'b11, 0, 0, 0, 0, 1, 0, 32'h80, 0, 0, 0, 0, 32'h66)});
        tv.push_back('{z, id});
        // Snoop miss: core1 reads 0x300, core0 not Modified; RAM shows ERROR once.
        tv.push_back('{mi(1, 0, 2'b10, 0, 2'b10, 0, FR, 0, 0, 32'h300, 0, 0), id});
        tv.push_back('{mi(1, 0, 2'b10, 0, 2'b10, 0, FR, 0, 0, 32'h300, 0, 0), me(2'b11, 2'b11, 2'b01, 0, 32'h300, 0, 0, 0, 0, 0, 0, 0, 0, 0)});
        tv.push_back('{mi(1, 0, 2'b10, 0, 2'b10, 0, ER, 0, 0, 32'h300, 0, 0), me(2'b11, 2'b11, 0, 0, 0, 0, 1, 0, 32'h300, 0, 0, 0, 0, 0)});
        tv.push_back('{mi(1, 0, 2'b10, 0, 2'b10, 0, AC, 32'hCAFEF00D, 0, 32'h300, 0, 0), me(2'b11, 2'b01, 0, 0, 0, 0, 1, 0, 32'h300, 0, 0, 32'hCAFEF00D, 0, 0)});
        tv.push_back('{z, id});
        // Plain read miss without cctrans: no snoop cycle.
        tv.push_back('{mi(1, 0, 2'b01, 0, 0, 0, FR, 0, 32'h400, 0, 0, 0), id});
        tv.push_back('{mi(1, 0, 2'b01, 0, 0, 0, AC, 32'h77, 32'h400, 0, 0, 0), me(2'b11, 2'b10, 0, 0, 0, 0, 1, 0, 32'h400, 0, 32'h77, 0, 0, 0)});
        tv.push_back('{z, id});

        iaddr = {32'h80, 32'h40};
        drive(mi(0, 0, 0, 0, 0, 0, FR, 0, 0, 0, 0, 0));
        @(posedge CLK);

        for (int r = 0; r < tv.size(); r++) begin
            @(negedge CLK);
            drive(tv[r].i);
            #1;
            check_all(r, tv[r].e);
        end

        // Reset during a RAM write drops the strobe and resets the pointer.
        @(negedge CLK);
        drive(mi(1, 0, 0, 2'b10, 0, 0, FR, 0, 0, 32'h500, 0, 32'h9));
        @(negedge CLK);
        drive(mi(1, 0, 0, 2'b10, 0, 0, BS, 0, 0, 32'h500, 0, 32'h9));
        #1;
        check("rst_mid ramWEN before", 64'(ramWEN), 64'd1);
        check("rst_mid ramaddr before", 64'(ramaddr), 64'h500);
        @(negedge CLK);
        drive(mi(0, 0, 0, 2'b11, 0, 0, BS, 0, 32'h510, 32'h500, 32'hAB, 32'h9));
        @(negedge CLK);
        drive(mi(1, 0, 0, 2'b11, 0, 0, BS, 0, 32'h510, 32'h500, 32'hAB, 32'h9));
        #1;
        check("rst_mid ramWEN after", 64'(ramWEN), 64'd0);
        check("rst_mid dwait after", 64'(dwait), 64'h3);
        @(negedge CLK);
        drive(mi(1, 0, 0, 2'b11, 0, 0, AC, 0, 32'h510, 32'h500, 32'hAB, 32'h9));
        #1;
        check("rst_mid regrant ramaddr", 64'(ramaddr), 64'h510);
        check("rst_mid regrant ramstore", 64'(ramstore), 64'hAB);
        check("rst_mid regrant dwait", 64'(dwait), 64'h2);
        @(negedge CLK);
        drive(z);

        // Request dropped mid-transaction still completes on ACCESS.
        @(negedge CLK);
        drive(mi(1, 0, 2'b01, 0, 0, 0, FR, 0, 32'h600, 0, 0, 0));
        @(negedge CLK);
        drive(mi(1, 0, 0, 0, 0, 0, BS, 0, 32'h600, 0, 0, 0));
        #1;
        check("drop ramREN", 64'(ramREN), 64'd1);
        check("drop ramaddr", 64'(ramaddr), 64'h600);
        @(negedge CLK);
        drive(mi(1, 0, 0, 0, 0, 0, AC, 32'h600D, 32'h600, 0, 0, 0));
        #1;
        check("drop dwait", 64'(dwait), 64'h2);
        check("drop dload", dload, 64'h600D);
        @(negedge CLK);
        drive(z);
        #1;
        check("drop back idle dwait", 64'(dwait), 64'h3);
        check("drop back idle state", 64'(dbg_state), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
